frame_bank_arbiter: RTL and testbench

FRAME_BANK_ARBITER -- requirements
Module: frame_bank_arbiter

---
 rtl/frame_bank_arbiter_if.sv | 48 ++++
 rtl/frame_bank_arbiter.sv | 133 +++++++++++++
 tb/tb_frame_bank_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_bank_arbiter_if.sv
// rtl/frame_bank_arbiter_if.sv - writer, scan-out and bank signals of the frame bank arbiter
//
// Purpose: bundles every non-clock/reset signal of frame_bank_arbiter.
//   master : the arbiter's view (drives bank ports, draw_start, rd_data, status pulses)
//   slave  : the surrounding system's view (writer, scan-out, vsync, bank read data)
// Signals:
//   vsync                 vertical sync, synchronous to clk
//   draw_start/draw_done  writer handshake pulses
//   wr_en/wr_addr/wr_data writer pixel strobe, address, value
//   rd_addr/rd_data       scan-out address and front-bank pixel
//   we0/addr0/wd0/do0     bank 0 port
//   we1/addr1/wd1/do1     bank 1 port
//   front_sel/swap/frame_drop  displayed bank index, swap pulse, dropped-frame pulse
interface frame_bank_arbiter_if #(
  parameter int ADDR_WIDTH = 19
);
  logic                  vsync;
  logic                  draw_start;
  logic                  draw_done;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_data;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_data;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic                  wd0;
  logic                  wd1;
  logic                  do0;
  logic                  do1;
  logic                  front_sel;
  logic                  swap;
  logic                  frame_drop;

  modport master (
    input  vsync, draw_done, wr_en, wr_addr, wr_data, rd_addr, do0, do1,
    output draw_start, rd_data, we0, we1, addr0, addr1, wd0, wd1,
           front_sel, swap, frame_drop
  );

  modport slave (
    output vsync, draw_done, wr_en, wr_addr, wr_data, rd_addr, do0, do1,
    input  draw_start, rd_data, we0, we1, addr0, addr1, wd0, wd1,
           front_sel, swap, frame_drop
  );
endinterface

// File: rtl/frame_bank_arbiter.sv
// rtl/frame_bank_arbiter.sv - double-buffered 1-bit frame bank arbiter with clear/draw/swap sequencing
//
// Purpose: owns two single-port pixel banks. The front bank (index front_sel) is
// read by scan-out; the back bank is cleared, then handed to the writer, then
// swapped to the front on the next vsync rising edge after the writer finishes.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  frame_bank_arbiter_if.master (see interface file for the signal list)
module frame_bank_arbiter #(
  parameter int ADDR_WIDTH = 19,
  parameter int DEPTH      = 307200
) (
  input logic                  clk,
  input logic                  rst,
  frame_bank_arbiter_if.master bus
);

  localparam logic [1:0] CLEAR     = 2'd0;
  localparam logic [1:0] DRAW      = 2'd1;
  localparam logic [1:0] WAIT_SWAP = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  front_sel;
  logic                  front_sel_q;
  logic                  vsync_q;
  logic                  draw_start_r;
  logic                  swap_r;
  logic                  frame_drop_r;

  logic                  vs_rise;
  logic                  back_we;
  logic                  back_wd;
  logic [ADDR_WIDTH-1:0] back_addr;

  assign vs_rise = bus.vsync & ~vsync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= CLEAR;
      clr_cnt      <= '0;
      front_sel    <= 1'b0;
      front_sel_q  <= 1'b0;
      vsync_q      <= 1'b0;
      draw_start_r <= 1'b0;
      swap_r       <= 1'b0;
      frame_drop_r <= 1'b0;
    end else begin
      vsync_q      <= bus.vsync;
      front_sel_q  <= front_sel;
      draw_start_r <= 1'b0;
      swap_r       <= 1'b0;
      frame_drop_r <= 1'b0;
      case (state)
        CLEAR: begin
          // A vsync while the back bank is still being cleared cannot be honoured.
          if (vs_rise) frame_drop_r <= 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            clr_cnt      <= '0;
            state        <= DRAW;
            draw_start_r <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        DRAW: begin
          // A vsync coincident with draw_done is still a drop; the swap needs
          // the frame to be complete before the edge arrives.
          if (vs_rise) frame_drop_r <= 1'b1;
          if (bus.draw_done) state <= WAIT_SWAP;
        end
        WAIT_SWAP: begin
          if (vs_rise) begin
            front_sel <= ~front_sel;
            swap_r    <= 1'b1;
            clr_cnt   <= '0;
            state     <= CLEAR;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  // Back bank port, selected by state. Reset gates the write enable directly so
  // an asserted rst stops bank writes in the same cycle, not at the next edge.
  always_comb begin
    back_we   = 1'b0;
    back_wd   = 1'b0;
    back_addr = '0;
    case (state)
      CLEAR: begin
        back_we   = 1'b1;
        back_addr = clr_cnt;
      end
      DRAW: begin
        back_we   = bus.wr_en;
        back_addr = bus.wr_addr;
        back_wd   = bus.wr_data;
      end
      default: begin
        back_we   = 1'b0;
        back_addr = '0;
        back_wd   = 1'b0;
      end
    endcase
    if (rst) back_we = 1'b0;
  end

  // Bank (front_sel) is read-only for scan-out; the other bank gets the back port.
  assign bus.we0   = front_sel & back_we;
  assign bus.wd0   = front_sel & back_wd;
  assign bus.addr0 = front_sel ? back_addr : bus.rd_addr;
  assign bus.we1   = ~front_sel & back_we;
  assign bus.wd1   = ~front_sel & back_wd;
  assign bus.addr1 = front_sel ? bus.rd_addr : back_addr;

  // Bank data returns one cycle after the address, so select it with the
  // delayed index to keep the pixel stream consistent across a swap.
  assign bus.rd_data = front_sel_q ? bus.do1 : bus.do0;

  assign bus.draw_start = draw_start_r;
  assign bus.swap       = swap_r;
  assign bus.frame_drop = frame_drop_r;
  assign bus.front_sel  = front_sel;

endmodule

// File: tb/tb_frame_bank_arbiter.sv
// tb/tb_frame_bank_arbiter.sv - directed self-checking bench for frame_bank_arbiter (DEPTH=16)
module tb_frame_bank_arbiter;

  localparam int AW = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  frame_bank_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  frame_bank_arbiter #(.ADDR_WIDTH(AW), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.vsync = 1'b0;
    bus.draw_done = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = 1'b0;
    bus.rd_addr = 5'd3;
    bus.do0 = 1'b1;
    bus.do1 = 1'b0;

    // Reset state
    repeat (2) tick();
    #1;
    chk("rst_front_sel", 32'(bus.front_sel), 32'd0);
    chk("rst_swap", 32'(bus.swap), 32'd0);
    chk("rst_frame_drop", 32'(bus.frame_drop), 32'd0);
    chk("rst_draw_start", 32'(bus.draw_start), 32'd0);
    chk("rst_we0", 32'(bus.we0), 32'd0);
    chk("rst_we1", 32'(bus.we1), 32'd0);
    chk("rst_addr0", 32'(bus.addr0), 32'd3);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd1);

    // First clear of bank 1, with a vsync edge dropped mid-clear
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) bus.vsync = 1'b1;
      if (i == 10) bus.vsync = 1'b0;
      #1;
      chk("clr1_addr1", 32'(bus.addr1), 32'(i));
      chk("clr1_we1", 32'(bus.we1), 32'd1);
      chk("clr1_wd1", 32'(bus.wd1), 32'd0);
      chk("clr1_we0", 32'(bus.we0), 32'd0);
      chk("clr1_draw_start", 32'(bus.draw_start), 32'd0);
      chk("clr1_frame_drop", 32'(bus.frame_drop), (i == 6) ? 32'd1 : 32'd0);
      chk("clr1_front_sel", 32'(bus.front_sel), 32'd0);
      tick();
    end

    // DRAW: writes pass to bank 1, including an out-of-range address
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'd5;
    bus.wr_data = 1'b1;
    #1;
    chk("draw_start_pulse", 32'(bus.draw_start), 32'd1);
    chk("draw_we1", 32'(bus.we1), 32'd1);
    chk("draw_addr1", 32'(bus.addr1), 32'd5);
    chk("draw_wd1", 32'(bus.wd1), 32'd1);
    chk("draw_we0", 32'(bus.we0), 32'd0);
    chk("draw_addr0", 32'(bus.addr0), 32'd3);
    tick();
    bus.wr_addr = 5'd20;
    bus.wr_data = 1'b0;
    #1;
    chk("draw_start_once", 32'(bus.draw_start), 32'd0);
    chk("oob_we1", 32'(bus.we1), 32'd1);
    chk("oob_addr1", 32'(bus.addr1), 32'd20);
    chk("oob_wd1", 32'(bus.wd1), 32'd0);
    tick();
    bus.wr_addr = 5'd7;
    bus.wr_data = 1'b1;
    bus.draw_done = 1'b1;
    #1;
    chk("done_we1", 32'(bus.we1), 32'd1);
    chk("done_addr1", 32'(bus.addr1), 32'd7);
    chk("done_wd1", 32'(bus.wd1), 32'd1);
    tick();

    // WAIT_SWAP: writer strobe ignored
    bus.draw_done = 1'b0;
    bus.wr_addr = 5'd5;
    #1;
    chk("wait_we1", 32'(bus.we1), 32'd0);
    chk("wait_addr1", 32'(bus.addr1), 32'd0);
    chk("wait_wd1", 32'(bus.wd1), 32'd0);
    tick();
    bus.wr_en = 1'b0;
    bus.vsync = 1'b1;
    #1;
    chk("pre_swap_rd_data", 32'(bus.rd_data), 32'd1);
    chk("pre_swap_swap", 32'(bus.swap), 32'd0);
    chk("pre_swap_front_sel", 32'(bus.front_sel), 32'd0);
    tick();

    // Swap cycle N
    #1;
    chk("swap_pulse", 32'(bus.swap), 32'd1);
    chk("swap_front_sel", 32'(bus.front_sel), 32'd1);
    chk("swap_we0", 32'(bus.we0), 32'd1);
    chk("swap_addr0", 32'(bus.addr0), 32'd0);
    chk("swap_wd0", 32'(bus.wd0), 32'd0);
    chk("swap_we1", 32'(bus.we1), 32'd0);
    chk("swap_addr1", 32'(bus.addr1), 32'd3);
    chk("swap_rd_data_n", 32'(bus.rd_data), 32'd1);
    tick();

    // Clear of bank 0; writer strobe and stray draw_done are ignored
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'd9;
    bus.wr_data = 1'b1;
    for (int i = 1; i < 16; i++) begin
      bus.draw_done = (i == 2);
      if (i == 3) bus.vsync = 1'b0;
      #1;
      if (i == 1) begin
        chk("swap_once", 32'(bus.swap), 32'd0);
        chk("swap_rd_data_n1", 32'(bus.rd_data), 32'd0);
      end
      chk("clr0_addr0", 32'(bus.addr0), 32'(i));
      chk("clr0_we0", 32'(bus.we0), 32'd1);
      chk("clr0_wd0", 32'(bus.wd0), 32'd0);
      chk("clr0_we1", 32'(bus.we1), 32'd0);
      chk("clr0_draw_start", 32'(bus.draw_start), 32'd0);
      tick();
    end

    // draw_done coincident with vsync edge: dropped, no swap
    bus.wr_en = 1'b0;
    bus.draw_done = 1'b1;
    bus.vsync = 1'b1;
    #1;
    chk("clr0_draw_start_pulse", 32'(bus.draw_start), 32'd1);
    chk("draw0_we0_idle", 32'(bus.we0), 32'd0);
    tick();
    bus.draw_done = 1'b0;
    bus.vsync = 1'b0;
    #1;
    chk("coinc_frame_drop", 32'(bus.frame_drop), 32'd1);
    chk("coinc_swap", 32'(bus.swap), 32'd0);
    chk("coinc_front_sel", 32'(bus.front_sel), 32'd1);
    chk("coinc_we0", 32'(bus.we0), 32'd0);
    chk("coinc_addr0", 32'(bus.addr0), 32'd0);
    tick();
    #1;
    chk("coinc_drop_once", 32'(bus.frame_drop), 32'd0);
    tick();
    bus.vsync = 1'b1;
    tick();
    #1;
    chk("swap2_pulse", 32'(bus.swap), 32'd1);
    chk("swap2_front_sel", 32'(bus.front_sel), 32'd0);
    chk("swap2_frame_drop", 32'(bus.frame_drop), 32'd0);
    chk("swap2_we1", 32'(bus.we1), 32'd1);
    chk("swap2_addr1", 32'(bus.addr1), 32'd0);
    chk("swap2_addr0", 32'(bus.addr0), 32'd3);
    chk("swap2_we0", 32'(bus.we0), 32'd0);
    tick();
    tick();
    #1;
    chk("clr2_addr1", 32'(bus.addr1), 32'd2);

    // Reset mid-clear: writes stop at once, clear restarts at 0
    rst = 1'b1;
    #1;
    chk("rst_mid_we1", 32'(bus.we1), 32'd0);
    chk("rst_mid_we0", 32'(bus.we0), 32'd0);
    chk("rst_mid_front_sel", 32'(bus.front_sel), 32'd0);
    chk("rst_mid_swap", 32'(bus.swap), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_we1", 32'(bus.we1), 32'd1);
    chk("post_rst_addr1", 32'(bus.addr1), 32'd0);
    tick();
    #1;
    chk("post_rst_addr1_next", 32'(bus.addr1), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
